// File: rtl/global_defs.sv
// Shared fetch-path constants and the refill responder state type.
package global_defs;

    localparam int ICACHE_DATA_BLOCK_SIZE = 64;
    localparam int ADDR_WIDTH             = 32;
    localparam int IMEM_LATENCY           = 10;
    localparam int IMEM_DEPTH             = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_resp_state_t;

endpackage

// File: rtl/fifo.sv
// In-order queue with occupancy count and synchronous flush.
// enq_ready reflects the pre-dequeue occupancy, so a full queue never accepts in a pop cycle.
module fifo #(
    parameter int ENTRY_WIDTH = 32,
    parameter int N_ENTRIES   = 2,
    localparam int PTR_W      = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
    localparam int CNT_W      = $clog2(N_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_aL,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [ENTRY_WIDTH-1:0] enq_data,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [ENTRY_WIDTH-1:0] deq_data,
    output logic [CNT_W-1:0]       count
);

    logic [ENTRY_WIDTH-1:0] mem_q [N_ENTRIES];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   push, pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_ENTRIES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign enq_ready = (count_q < CNT_W'(N_ENTRIES));
    assign deq_valid = (count_q != '0);
    assign deq_data  = mem_q[head_q];
    assign count     = count_q;

    assign push = enq_valid && enq_ready && !flush;
    assign pop  = deq_ready && deq_valid && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d  = nxt(tail_q);
            count_d = count_d + CNT_W'(1);
        end
        if (pop) begin
            head_d  = nxt(head_q);
            count_d = count_d - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= enq_data;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory refill responder used as the DRAM model.
// Optional recovery flush port enabled by defining IMEM_RESP_CANCEL_EN.
//
// state | meaning
// IDLE  | queue empty, nothing in service
// WAIT  | head request counting down its latency
// RESP  | head request returned this cycle and popped
module imem_responder #(
    parameter int BLOCK_SIZE  = global_defs::ICACHE_DATA_BLOCK_SIZE,
    parameter int ADDR_WIDTH  = global_defs::ADDR_WIDTH,
    parameter int MEM_DEPTH   = global_defs::IMEM_DEPTH,
    parameter int LATENCY     = global_defs::IMEM_LATENCY,
    parameter int REQ_Q_DEPTH = 2,
    localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
`ifdef IMEM_RESP_CANCEL_EN
    input  logic                  cancel,
`endif
    input  logic                  mem_we,
    input  logic [IDX_W-1:0]      mem_waddr,
    input  logic [BLOCK_SIZE-1:0] mem_wdata,
    output logic [BLOCK_SIZE-1:0] dram_response,
    output logic                  dram_response_valid,
    output logic [ADDR_WIDTH-1:0] dram_response_addr,
    output logic                  busy
);

    import global_defs::*;

    localparam int OFF_W   = $clog2(BLOCK_SIZE / 8);
    localparam int CNT_W   = $clog2(LATENCY);
    localparam int Q_CNT_W = $clog2(REQ_Q_DEPTH + 1);
    localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(LATENCY - 2);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;

    imem_resp_state_t      state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BLOCK_SIZE-1:0] resp_data_q;
    logic [ADDR_WIDTH-1:0] resp_addr_q;
    logic [BLOCK_SIZE-1:0] mem_q [MEM_DEPTH];

    logic                  cancel_act;
    logic                  push;
    logic                  resp_fire;
    logic                  q_enq_ready;
    logic                  q_deq_valid;
    logic [ADDR_WIDTH-1:0] q_head;
    logic [Q_CNT_W-1:0]    q_count;
    logic [ADDR_WIDTH-1:0] head_aligned;
    logic [IDX_W-1:0]      rd_idx;
    logic [BLOCK_SIZE-1:0] rd_data;

`ifdef IMEM_RESP_CANCEL_EN
    assign cancel_act = cancel;
`else
    assign cancel_act = 1'b0;
`endif

    assign req_ready = q_enq_ready && !cancel_act;
    assign push      = req_valid && req_ready;
    assign busy      = q_deq_valid;

    fifo #(
        .ENTRY_WIDTH (ADDR_WIDTH),
        .N_ENTRIES   (REQ_Q_DEPTH)
    ) u_req_q (
        .clk       (clk),
        .rst_aL    (rst_aL),
        .flush     (cancel_act),
        .enq_valid (push),
        .enq_ready (q_enq_ready),
        .enq_data  (req_addr),
        .deq_valid (q_deq_valid),
        .deq_ready (resp_fire),
        .deq_data  (q_head),
        .count     (q_count)
    );

    // Index drops the byte offset and wraps modulo the store depth.
    assign head_aligned = q_head & ALIGN_MASK;
    assign rd_idx       = q_head[OFF_W +: IDX_W];
    assign rd_data      = mem_q[rd_idx];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        resp_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                resp_fire = 1'b1;
                // Queue stays non-empty if more than the head is queued or a new one lands now.
                if ((q_count > Q_CNT_W'(1)) || push) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (cancel_act) begin
            state_d   = IDLE;
            cnt_d     = '0;
            resp_fire = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (resp_fire) begin
                resp_data_q <= rd_data;
                resp_addr_q <= head_aligned;
            end
        end
    end

    // Store is read combinationally in RESP, so a same-cycle preload write is not seen.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign dram_response_valid = resp_fire;
    assign dram_response       = resp_fire ? rd_data      : resp_data_q;
    assign dram_response_addr  = resp_fire ? head_aligned : resp_addr_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: vector table plus latency/reset/cancel sequences.
module tb_imem_responder;

    localparam int LAT   = 10;
    localparam int AW    = 32;
    localparam int BW    = 64;
    localparam int DEPTH = 1024;
    localparam int IW    = 10;

    logic          clk;
    logic          rst_aL;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          cancel;
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] dram_response;
    logic          dram_response_valid;
    logic [AW-1:0] dram_response_addr;
    logic          busy;

    imem_responder dut (
        .clk                 (clk),
        .rst_aL              (rst_aL),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_addr            (req_addr),
`ifdef IMEM_RESP_CANCEL_EN
        .cancel              (cancel),
`endif
        .mem_we              (mem_we),
        .mem_waddr           (mem_waddr),
        .mem_wdata           (mem_wdata),
        .dram_response       (dram_response),
        .dram_response_valid (dram_response_valid),
        .dram_response_addr  (dram_response_addr),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } sb_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] exp_addr;
        int            exp_idx;
    } vec_t;

    sb_t           sb[$];
    vec_t          vecs[7];
    logic [BW-1:0] mdl_mem [DEPTH];
    logic [BW-1:0] last_data;
    logic [AW-1:0] last_addr;
    int            last_resp = -1000;
    int            n_checks  = 0;
    int            n_fail    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cyc=%0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        sb_t e;
        if (rst_aL && dram_response_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp got=valid exp=none (cyc=%0d addr=%h)", cyc, dram_response_addr);
            end else begin
                e = sb.pop_front();
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
                check("resp_data", dram_response, e.data);
                check("resp_addr", 64'(dram_response_addr), 64'(e.addr));
                last_data = e.data;
                last_addr = e.addr;
            end
        end
    end

    task automatic do_req(input logic [AW-1:0] a, input logic [AW-1:0] ea, input int idx, output int t_acc);
        int  n;
        sb_t e;
        n         = 0;
        t_acc     = -1;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout got=ready0 exp=ready1 (addr=%h)", a);
        end else begin
            t_acc  = cyc;
            e.cyc  = ((cyc + LAT) > (last_resp + LAT)) ? (cyc + LAT) : (last_resp + LAT);
            e.addr = ea;
            e.data = mdl_mem[idx];
            last_resp = e.cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout got=%0d_pending exp=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
        check("busy_idle", 64'(busy), 64'(0));
        check("hold_data", dram_response, last_data);
        check("hold_addr", 64'(dram_response_addr), 64'(last_addr));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input int idx, input logic [BW-1:0] v);
        mem_we    = 1'b1;
        mem_waddr = IW'(idx);
        mem_wdata = v;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        mdl_mem[idx] = v;
    endtask

    initial begin
        int t, t1, t2, t3, c;

        vecs[0] = '{32'h0000_002C, 32'h0000_0028, 5};
        vecs[1] = '{32'h0000_2000, 32'h0000_2000, 0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 0};
        vecs[3] = '{32'h0000_007F, 32'h0000_0078, 15};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF8, 1023};
        vecs[5] = '{32'h0000_1234, 32'h0000_1230, 582};
        vecs[6] = '{32'h0000_2008, 32'h0000_2008, 1};

        clk       = 1'b0;
        rst_aL    = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        cancel    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        last_data = '0;
        last_addr = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(dram_response_valid), 64'(0));
        check("rst_data", dram_response, 64'(0));
        check("rst_addr", 64'(dram_response_addr), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(1));
        rst_aL = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            preload(i, {16'hC0DE, 16'(i), 16'(i * 7), 16'hBEEF ^ 16'(i)});
        end
        preload(5, 64'hDEAD_BEEF_0000_0013);

        for (int i = 0; i < 7; i++) begin
            do_req(vecs[i].addr, vecs[i].exp_addr, vecs[i].exp_idx, t);
            check("busy_pending", 64'(busy), 64'(1));
            drain();
        end

        // Back-to-back with a full queue.
        do_req(32'h0000_0000, 32'h0000_0000, 0, t1);
        do_req(32'h0000_0008, 32'h0000_0008, 1, t2);
        check("b2b_second_accept", 64'(t2 - t1), 64'(1));
        #1;
        check("b2b_ready_full", 64'(req_ready), 64'(0));
        do_req(32'h0000_0010, 32'h0000_0010, 2, t3);
        check("b2b_third_accept", 64'(t3 - t1), 64'(11));
        drain();

        // Preload write landing in the response cycle returns the old block.
        do_req(32'h0000_0028, 32'h0000_0028, 5, t);
        wait_until(t + LAT);
        mem_we    = 1'b1;
        mem_waddr = IW'(5);
        mem_wdata = 64'h0123_4567_89AB_CDEF;
        @(posedge clk);
        #1;
        mem_we     = 1'b0;
        mdl_mem[5] = 64'h0123_4567_89AB_CDEF;
        drain();
        do_req(32'h0000_0028, 32'h0000_0028, 5, t);
        drain();

        // Reset while a request is pending: it must never respond.
        do_req(32'h0000_0030, 32'h0000_0030, 6, t);
        wait_until(t + 6);
        rst_aL = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_ready", 64'(req_ready), 64'(1));
        check("midrst_valid", 64'(dram_response_valid), 64'(0));
        check("midrst_data", dram_response, 64'(0));
        check("midrst_addr", 64'(dram_response_addr), 64'(0));
        sb.delete();
        last_resp = -1000;
        wait_until(t + 8);
        rst_aL = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("postrst_busy", 64'(busy), 64'(0));
        do_req(32'h0000_002C, 32'h0000_0028, 5, t);
        drain();

`ifdef IMEM_RESP_CANCEL_EN
        do_req(32'h0000_0040, 32'h0000_0040, 8, t1);
        do_req(32'h0000_0048, 32'h0000_0048, 9, t2);
        c = t1 + LAT - 1;
        wait_until(c);
        cancel = 1'b1;
        @(negedge clk);
        check("cancel_valid", 64'(dram_response_valid), 64'(0));
        check("cancel_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        cancel = 1'b0;
        sb.delete();
        last_resp = -1000;
        check("cancel_busy", 64'(busy), 64'(0));
        do_req(32'h0000_0050, 32'h0000_0050, 10, t3);
        check("cancel_next_accept", 64'(t3), 64'(c + 1));
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Memory-side responder for the instruction-fetch refill interface. Accepts block-refill requests issued on an icache miss and returns one `ICACHE_DATA_BLOCK_SIZE` block per request after a fixed latency, as a one-cycle `dram_response_valid` pulse with data. It sits between the fetch unit's miss path and the backing instruction memory. Benches and full-core simulation use it as the DRAM model.

## Interface
- `BLOCK_SIZE`, default `ICACHE_DATA_BLOCK_SIZE` (64): bits per block and per response.
- `ADDR_WIDTH`, default `ADDR_WIDTH` (32): request address width.
- `MEM_DEPTH`, default 1024: number of blocks in backing store; must be a power of 2.
- `LATENCY`, default 10: cycles from acceptance to response; must be ≥ 2.
- `REQ_Q_DEPTH`, default 2: maximum outstanding requests, including the one in service.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_aL`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  refill request present.
- `req_ready`  out  1  request can be accepted this cycle.
- `req_addr`  in  ADDR_WIDTH  fetch PC that missed; byte address.
- `cancel`  in  1  recovery flush of all outstanding requests. Present only under `IMEM_RESP_CANCEL_EN`.
- `mem_we`  in  1  preload write enable for the backing store.
- `mem_waddr`  in  log2(MEM_DEPTH)  preload block index.
- `mem_wdata`  in  BLOCK_SIZE  preload data.
- `dram_response`  out  BLOCK_SIZE  returned block.
- `dram_response_valid`  out  1  one-cycle pulse marking a valid response.
- `dram_response_addr`  out  ADDR_WIDTH  block-aligned address of the response; low log2(BLOCK_SIZE/8) bits are zero.
- `busy`  out  1  at least one request is outstanding.

## Operation
- **Acceptance:** a request is accepted on `req_valid && req_ready`. `req_ready` = outstanding count < `REQ_Q_DEPTH`. `req_ready` is combinational from the count only; it does not depend on `req_valid`.
- **Ordering:** accepted requests are queued in order. The head of the queue is the request in service. It pops in its response cycle.
- **Indexing:** block index = `req_addr[ADDR_WIDTH-1:3]` modulo `MEM_DEPTH`. Out-of-range addresses wrap silently.
- **FSM `imem_resp_state_t`:**
  - `IDLE`: queue empty. Goes to `WAIT` in the cycle after an acceptance.
  - `WAIT`: a down-counter of width `$clog2(LATENCY)` is loaded with `LATENCY-2` on entry and decrements each cycle. At 0 the FSM goes to `RESP`.
  - `RESP`: drives `dram_response_valid=1` with the data and address, and pops the head. Next state is `WAIT`, with the counter reloaded, if the queue is still non-empty; otherwise `IDLE`.
- **Data read:** the store is read in the `RESP` cycle. A preload write to the same index in that cycle is not visible: the response returns the old data.
- **Pop and push in the same cycle:** `req_ready` reflects the pre-pop count. A full queue therefore does not accept a request in its `RESP` cycle.
- **Data hold:** `dram_response` and `dram_response_addr` hold their last values when `dram_response_valid=0`.
- **`busy`:** equals queue non-empty.

## Timing
- **Reset values:** `dram_response_valid=0`, `dram_response=0`, `dram_response_addr=0`, `busy=0`, `req_ready=1`. FSM in `IDLE`, queue empty, counter 0. Backing-store contents are not reset.
- **Single request:** accepted at cycle T → response at cycle T+LATENCY.
- **Back-to-back:** a queued request's response comes at max(T_accept + LATENCY, R_prev + LATENCY), where R_prev is the previous response cycle. Responses are therefore never closer than LATENCY cycles apart.
- **Reset mid-operation:** all queued requests are lost and no response is ever produced for them. Outputs return to reset values immediately (asynchronous reset).

## Configuration
- **`IMEM_RESP_CANCEL_EN` defined:** the `cancel` port exists.
  - `cancel=1` in cycle C empties the queue and forces the FSM to `IDLE` at the end of C.
  - `dram_response_valid` is forced to 0 in cycle C.
  - `req_ready=0` in cycle C, so no request is accepted that cycle.
  - A request in cycle C+1 is accepted normally.
- **Undefined:** the `cancel` port is absent and every accepted request receives exactly one response.

## Structure
- **Shared package/defines:** `imem_resp_state_t` (`IDLE`, `WAIT`, `RESP`) and the `IMEM_LATENCY` and `IMEM_DEPTH` default constants go in `global_defs` alongside the existing icache constants.
- **Sub-module:** the request queue reuses the existing `fifo` module, configured as `ENTRY_WIDTH=ADDR_WIDTH`, `N_ENTRIES=REQ_Q_DEPTH`. Its `enq_ready` drives `req_ready`, gated by `cancel` when `IMEM_RESP_CANCEL_EN` is defined. The FSM, counter and backing array live in this module.

## Test plan
- Preload block 5 = 64'hDEAD_BEEF_0000_0013; request `req_addr`=0x2C at T=3 → `dram_response_valid` high only at T=13, data 64'hDEAD_BEEF_0000_0013, `dram_response_addr`=0x28.
- Requests 0x00 at T=1 and 0x08 at T=2, then `req_valid` held with 0x10 → `req_ready`=0 from T=3. Responses at T=11 and T=21. The third request is accepted at T=12 and responds at T=31.
- `req_addr`=0x2000 with `MEM_DEPTH`=1024 → index 0 (wrap); the response carries block 0.
- Preload write to block 5 in the response cycle of a request for 0x28 → response returns the old value; a second request for 0x28 returns the new value.
- Assert `rst_aL`=0 at cycle 6 of a pending request, release at cycle 8 → no response ever; `busy`=0 and `req_ready`=1 immediately.
- With `IMEM_RESP_CANCEL_EN`: two outstanding requests, `cancel` in the cycle before the first response → no responses. A new request the cycle after `cancel` responds exactly LATENCY cycles later.
